// File: rtl/imm_encoder.sv
// imm_encoder: streaming RV32 immediate packer, the inverse of an immediate extender.
// Scatters a 32-bit signed immediate into the I/S/B/J field positions of a base
// instruction word and range-checks it. Results go into a 2-entry output FIFO
// with a valid/ready handshake. Saturating counters track accepted and erroring
// requests.
//
// Optional feature: define IMM_ENC_J_EN to support J-type (immsrc=2'b11).
// Without it, immsrc=2'b11 is reported as an unsupported format (out_err=1,
// out_instr=base).
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   request valid
//   in_ready   out  request can be accepted (buffer occupancy < 2)
//   immsrc     in   [1:0] format: 00 I, 01 S, 10 B, 11 J
//   imm        in   [31:0] signed immediate (byte offset for B/J)
//   base       in   [31:0] instruction word; immediate-field bits are replaced
//   out_valid  out  out_instr/out_err valid
//   out_ready  in   consumer accepts output
//   out_instr  out  [31:0] packed instruction
//   out_err    out  immediate out of range or format unsupported
//   enc_count  out  [CNT_W-1:0] accepted requests, saturating
//   err_count  out  [CNT_W-1:0] accepted erroring requests, saturating
module imm_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       immsrc,
  input  logic [31:0]      imm,
  input  logic [31:0]      base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  // Combinational encoder
  logic [31:0] enc_instr;
  logic        enc_err;
  logic        fits_12;
  logic        fits_13;
`ifdef IMM_ENC_J_EN
  logic        fits_21;
`endif

  always_comb begin
    fits_12   = (&imm[31:11]) | ~(|imm[31:11]);
    fits_13   = (&imm[31:12]) | ~(|imm[31:12]);
`ifdef IMM_ENC_J_EN
    fits_21   = (&imm[31:20]) | ~(|imm[31:20]);
`endif
    enc_instr = base;
    enc_err   = 1'b0;
    // On error the format's immediate fields are cleared; base bits stay.
    case (immsrc)
      2'b00: begin
        if (fits_12) begin
          enc_instr[31:20] = imm[11:0];
        end else begin
          enc_instr[31:20] = '0;
          enc_err          = 1'b1;
        end
      end
      2'b01: begin
        if (fits_12) begin
          enc_instr[31:25] = imm[11:5];
          enc_instr[11:7]  = imm[4:0];
        end else begin
          enc_instr[31:25] = '0;
          enc_instr[11:7]  = '0;
          enc_err          = 1'b1;
        end
      end
      2'b10: begin
        if (fits_13 && !imm[0]) begin
          enc_instr[31]    = imm[12];
          enc_instr[7]     = imm[11];
          enc_instr[30:25] = imm[10:5];
          enc_instr[11:8]  = imm[4:1];
        end else begin
          enc_instr[31:25] = '0;
          enc_instr[11:7]  = '0;
          enc_err          = 1'b1;
        end
      end
      default: begin
`ifdef IMM_ENC_J_EN
        if (fits_21 && !imm[0]) begin
          enc_instr[31]    = imm[20];
          enc_instr[30:21] = imm[10:1];
          enc_instr[20]    = imm[11];
          enc_instr[19:12] = imm[19:12];
        end else begin
          enc_instr[31:12] = '0;
          enc_err          = 1'b1;
        end
`else
        enc_instr = base;
        enc_err   = 1'b1;
`endif
      end
    endcase
  end

  // 2-entry FIFO as head (the output register) plus one tail slot. Keeping the
  // head as the output register lets out_instr/out_err hold their last value
  // when the buffer drains.
  logic             head_valid_q, head_valid_d;
  logic [31:0]      head_instr_q, head_instr_d;
  logic             head_err_q,   head_err_d;
  logic             tail_valid_q, tail_valid_d;
  logic [31:0]      tail_instr_q, tail_instr_d;
  logic             tail_err_q,   tail_err_d;
  logic [CNT_W-1:0] enc_count_q,  enc_count_d;
  logic [CNT_W-1:0] err_count_q,  err_count_d;
  logic             push;
  logic             pop;

  assign in_ready  = !(head_valid_q && tail_valid_q);
  assign out_valid = head_valid_q;
  assign out_instr = head_instr_q;
  assign out_err   = head_err_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

  always_comb begin
    push         = in_valid && in_ready;
    pop          = head_valid_q && out_ready;
    head_valid_d = head_valid_q;
    head_instr_d = head_instr_q;
    head_err_d   = head_err_q;
    tail_valid_d = tail_valid_q;
    tail_instr_d = tail_instr_q;
    tail_err_d   = tail_err_q;
    enc_count_d  = enc_count_q;
    err_count_d  = err_count_q;

    if (tail_valid_q) begin
      // Full: no push possible; a pop advances the tail into the head.
      if (pop) begin
        head_instr_d = tail_instr_q;
        head_err_d   = tail_err_q;
        tail_valid_d = 1'b0;
      end
    end else if (!head_valid_q || pop) begin
      // Empty, or one entry leaving: the new request (if any) becomes head.
      head_valid_d = push;
      if (push) begin
        head_instr_d = enc_instr;
        head_err_d   = enc_err;
      end
    end else if (push) begin
      tail_valid_d = 1'b1;
      tail_instr_d = enc_instr;
      tail_err_d   = enc_err;
    end

    if (push) begin
      if (enc_count_q != '1) enc_count_d = enc_count_q + CNT_W'(1);
      if (enc_err && (err_count_q != '1)) err_count_d = err_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_valid_q <= 1'b0;
      head_instr_q <= '0;
      head_err_q   <= 1'b0;
      tail_valid_q <= 1'b0;
      tail_instr_q <= '0;
      tail_err_q   <= 1'b0;
      enc_count_q  <= '0;
      err_count_q  <= '0;
    end else begin
      head_valid_q <= head_valid_d;
      head_instr_q <= head_instr_d;
      head_err_q   <= head_err_d;
      tail_valid_q <= tail_valid_d;
      tail_instr_q <= tail_instr_d;
      tail_err_q   <= tail_err_d;
      enc_count_q  <= enc_count_d;
      err_count_q  <= err_count_d;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed testbench for imm_encoder. A second instance with narrow counters
// exercises saturation.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  immsrc = 2'b00;
  logic [31:0] imm = '0;
  logic [31:0] base = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [1:0]  s_immsrc = 2'b00;
  logic [31:0] s_imm = '0;
  logic [31:0] s_base = '0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic [31:0] s_out_instr;
  logic        s_out_err;
  logic [3:0]  s_enc_count;
  logic [3:0]  s_err_count;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  always #5 clk = ~clk;

  imm_encoder #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .immsrc(immsrc), .imm(imm), .base(base), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  imm_encoder #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .immsrc(s_immsrc), .imm(s_imm), .base(s_base), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_instr(s_out_instr), .out_err(s_out_err),
    .enc_count(s_enc_count), .err_count(s_err_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [1:0] src, input logic [31:0] b, input logic [31:0] i);
    in_valid = 1'b1;
    immsrc   = src;
    base     = b;
    imm      = i;
  endtask

  initial begin
    // Reset
    tick();
    tick();
    reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_err",   32'(out_err), 32'd0);
    chk("rst_enc_count", 32'(enc_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready",  32'(in_ready), 32'd1);

    // I-type, negative immediate
    out_ready = 1'b1;
    req(2'b00, 32'h0000_0013, 32'hFFFF_FFFF);
    tick();
    chk("i_valid", 32'(out_valid), 32'd1);
    chk("i_instr", out_instr, 32'hFFF0_0013);
    chk("i_err",   32'(out_err), 32'd0);
    chk("i_enc",   32'(enc_count), 32'd1);

    // S-type (push+pop at occupancy 1)
    req(2'b01, 32'h0000_2023, 32'h0000_0024);
    tick();
    chk("s_valid", 32'(out_valid), 32'd1);
    chk("s_instr", out_instr, 32'h0200_2223);
    chk("s_err",   32'(out_err), 32'd0);

    // B-type, -4
    req(2'b10, 32'h0000_0063, 32'hFFFF_FFFC);
    tick();
    chk("b_instr", out_instr, 32'hFE00_0EE3);
    chk("b_err",   32'(out_err), 32'd0);

    // B-type, misaligned
    req(2'b10, 32'h0000_0063, 32'h0000_0003);
    tick();
    chk("b_mis_instr", out_instr, 32'h0000_0063);
    chk("b_mis_err",   32'(out_err), 32'd1);
    chk("b_mis_errc",  32'(err_count), 32'd1);

    // I-type out of range
    req(2'b00, 32'h0000_0013, 32'h0000_0800);
    tick();
    chk("i_rng_instr", out_instr, 32'h0000_0013);
    chk("i_rng_err",   32'(out_err), 32'd1);
    chk("i_rng_errc",  32'(err_count), 32'd2);
    chk("i_rng_enc",   32'(enc_count), 32'd5);

    // J-type (format depends on build option)
    req(2'b11, 32'h0000_006F, 32'h0000_0008);
    tick();
`ifdef IMM_ENC_J_EN
    chk("j_instr", out_instr, 32'h0080_006F);
    chk("j_err",   32'(out_err), 32'd0);
    chk("j_errc",  32'(err_count), 32'd2);
`else
    chk("j_instr", out_instr, 32'h0000_006F);
    chk("j_err",   32'(out_err), 32'd1);
    chk("j_errc",  32'(err_count), 32'd3);
`endif
    chk("j_enc", 32'(enc_count), 32'd6);

    // Drain: output data holds once empty
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
`ifdef IMM_ENC_J_EN
    chk("drain_hold", out_instr, 32'h0080_006F);
`else
    chk("drain_hold", out_instr, 32'h0000_006F);
`endif

    // Backpressure
    out_ready = 1'b0;
    req(2'b00, 32'h0000_0013, 32'h0000_0001);
    tick();
    chk("bp_a_valid", 32'(out_valid), 32'd1);
    chk("bp_a_instr", out_instr, 32'h0010_0013);
    chk("bp_a_ready", 32'(in_ready), 32'd1);
    req(2'b00, 32'h0000_0013, 32'h0000_0002);
    tick();
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    chk("bp_b_stable",   out_instr, 32'h0010_0013);
    req(2'b00, 32'h0000_0013, 32'h0000_0003);
    tick();
    chk("bp_c_held_ready", 32'(in_ready), 32'd0);
    chk("bp_c_stable",     out_instr, 32'h0010_0013);
    chk("bp_c_held_enc",   32'(enc_count), 32'd8);
    out_ready = 1'b1;
    tick();
    chk("bp_pop_a_instr", out_instr, 32'h0020_0013);
    chk("bp_pop_a_ready", 32'(in_ready), 32'd1);
    chk("bp_pop_a_enc",   32'(enc_count), 32'd8);
    tick();
    chk("bp_c_acc_instr", out_instr, 32'h0030_0013);
    chk("bp_c_acc_enc",   32'(enc_count), 32'd9);

    // Fill to two entries, then reset mid-operation
    out_ready = 1'b0;
    req(2'b00, 32'h0000_0013, 32'h0000_0004);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_enc",   32'(enc_count), 32'd0);
    chk("mid_rst_errc",  32'(err_count), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    // Saturation on the 4-bit-counter instance: 20 erroring accepts
    s_out_ready = 1'b1;
    s_in_valid  = 1'b1;
    s_immsrc    = 2'b00;
    s_base      = 32'h0000_0013;
    s_imm       = 32'h0000_0800;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_enc_14", 32'(s_enc_count), 32'd14);
    chk("sat_err_14", 32'(s_err_count), 32'd14);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_enc_hold", 32'(s_enc_count), 32'd15);
    chk("sat_err_hold", 32'(s_err_count), 32'd15);
    s_imm = 32'h0000_0005;
    tick();
    s_in_valid = 1'b0;
    chk("sat_good_instr", s_out_instr, 32'h0050_0013);
    chk("sat_good_enc",   32'(s_enc_count), 32'd15);
    chk("sat_good_errc",  32'(s_err_count), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
